// File: rtl/alu_hilo_unit_if.sv
// Execute-stage bus between the pipeline and the ALU/HI-LO unit.
// The master drives operands and decode; the slave returns the result, stall and HI/LO.
interface alu_hilo_unit_if;
  logic        ex_valid;
  logic [31:0] srca;
  logic [31:0] srcb;
  logic [3:0]  alucontrol;
  logic        hien;
  logic        loen;
  logic [31:0] aluresult;
  logic        zero;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output ex_valid, srca, srcb, alucontrol, hien, loen,
    input  aluresult, zero, stall, hi, lo
  );

  modport slave (
    input  ex_valid, srca, srcb, alucontrol, hien, loen,
    output aluresult, zero, stall, hi, lo
  );
endinterface

// File: rtl/alu_hilo_unit.sv
// Execute-stage ALU with a 32-iteration MULT/DIV engine writing the HI/LO pair.
// Define ALU_HILO_FAST_MUL_EN to compute MULT in a single cycle (DIV stays iterative).
module alu_hilo_unit (
  input logic            clk,
  input logic            reset,
  alu_hilo_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t      state, state_next;
  logic [4:0]  count;
  logic [31:0] acc_hi, acc_lo, opnd;
  logic        neg_res, neg_a, b_zero, hien_q, loen_q;
  logic [31:0] hi_q, lo_q;

  logic        op_mult, op_div, start;
  logic        stall_c, load, iterate, hi_we, lo_we;
  logic [31:0] hi_d, lo_d;

  logic [32:0] mul_sum;
  logic [31:0] mul_hi, mul_lo;
  logic [63:0] mul_prod, mul_fix;
  logic [32:0] div_shift;
  logic        div_ok;
  logic [31:0] div_hi, div_lo, div_q, div_r;

  function automatic logic [31:0] mag(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

  assign op_mult = (bus.alucontrol == 4'b1000);
  assign op_div  = (bus.alucontrol == 4'b1001);
  assign start   = (state == IDLE) && bus.ex_valid && (op_mult || op_div)
                   && (bus.hien || bus.loen);

  // One shift-add step: acc_lo holds the remaining multiplier bits, opnd the multiplicand.
  assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : 33'd0);
  assign mul_hi   = mul_sum[32:1];
  assign mul_lo   = {mul_sum[0], acc_lo[31:1]};
  assign mul_prod = {mul_hi, mul_lo};
  assign mul_fix  = neg_res ? (~mul_prod + 64'd1) : mul_prod;

  // One restoring step: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
  assign div_shift = {acc_hi, acc_lo[31]};
  assign div_ok    = (div_shift >= {1'b0, opnd});
  assign div_hi    = div_ok ? (div_shift[31:0] - opnd) : div_shift[31:0];
  assign div_lo    = {acc_lo[30:0], div_ok};
  assign div_q     = b_zero ? 32'hFFFF_FFFF : (neg_res ? (~div_lo + 32'd1) : div_lo);
  assign div_r     = neg_a ? (~div_hi + 32'd1) : div_hi;

`ifdef ALU_HILO_FAST_MUL_EN
  logic signed [63:0] fast_prod;
  assign fast_prod = $signed(bus.srca) * $signed(bus.srcb);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    stall_c    = 1'b0;
    load       = 1'b0;
    iterate    = 1'b0;
    hi_we      = 1'b0;
    lo_we      = 1'b0;
    hi_d       = hi_q;
    lo_d       = lo_q;
    case (state)
      IDLE: begin
        if (start) begin
          stall_c = 1'b1;
          load    = 1'b1;
          if (op_mult) begin
`ifdef ALU_HILO_FAST_MUL_EN
            hi_we      = bus.hien;
            lo_we      = bus.loen;
            hi_d       = fast_prod[63:32];
            lo_d       = fast_prod[31:0];
            state_next = DONE;
`else
            state_next = MUL;
`endif
          end else begin
            state_next = DIV;
          end
        end
      end
      MUL: begin
        stall_c = 1'b1;
        iterate = 1'b1;
        if (count == 5'd0) begin
          hi_we      = hien_q;
          lo_we      = loen_q;
          hi_d       = mul_fix[63:32];
          lo_d       = mul_fix[31:0];
          state_next = DONE;
        end
      end
      DIV: begin
        stall_c = 1'b1;
        iterate = 1'b1;
        if (count == 5'd0) begin
          hi_we      = hien_q;
          lo_we      = loen_q;
          hi_d       = div_r;
          lo_d       = div_q;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count   <= 5'd0;
      acc_hi  <= 32'd0;
      acc_lo  <= 32'd0;
      opnd    <= 32'd0;
      neg_res <= 1'b0;
      neg_a   <= 1'b0;
      b_zero  <= 1'b0;
      hien_q  <= 1'b0;
      loen_q  <= 1'b0;
    end else if (load) begin
      count   <= 5'd31;
      acc_hi  <= 32'd0;
      acc_lo  <= op_mult ? mag(bus.srcb) : mag(bus.srca);
      opnd    <= op_mult ? mag(bus.srca) : mag(bus.srcb);
      neg_res <= bus.srca[31] ^ bus.srcb[31];
      neg_a   <= bus.srca[31];
      b_zero  <= (bus.srcb == 32'd0);
      hien_q  <= bus.hien;
      loen_q  <= bus.loen;
    end else if (iterate) begin
      count  <= count - 5'd1;
      acc_hi <= (state == MUL) ? mul_hi : div_hi;
      acc_lo <= (state == MUL) ? mul_lo : div_lo;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q <= 32'd0;
      lo_q <= 32'd0;
    end else begin
      if (hi_we) hi_q <= hi_d;
      if (lo_we) lo_q <= lo_d;
    end
  end

  always_comb begin
    case (bus.alucontrol)
      4'b0000: bus.aluresult = bus.srca & bus.srcb;
      4'b0001: bus.aluresult = bus.srca | bus.srcb;
      4'b0010: bus.aluresult = bus.srca + bus.srcb;
      4'b0110: bus.aluresult = bus.srca - bus.srcb;
      4'b0111: bus.aluresult = {31'd0, ($signed(bus.srca) < $signed(bus.srcb))};
      4'b1010: bus.aluresult = hi_q;
      4'b1011: bus.aluresult = lo_q;
      default: bus.aluresult = 32'd0;
    endcase
  end

  assign bus.zero  = (bus.aluresult == 32'd0);
  assign bus.stall = stall_c & reset;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;

endmodule

// File: tb/tb_alu_hilo_unit.sv
// Randomized self-checking bench for alu_hilo_unit against an arithmetic reference model.
// Honours ALU_HILO_FAST_MUL_EN for the expected MULT stall length.
module tb_alu_hilo_unit;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  logic [31:0] hi_exp, lo_exp;

  alu_hilo_unit_if bus ();

  alu_hilo_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] ref_comb(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return 32'((sa + sb) & 64'hFFFF_FFFF);
      4'b0110: return 32'((sa - sb) & 64'hFFFF_FFFF);
      4'b0111: return (sa < sb) ? 32'd1 : 32'd0;
      4'b1010: return hi_exp;
      4'b1011: return lo_exp;
      default: return 32'd0;
    endcase
  endfunction

  task automatic do_comb(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    @(negedge clk);
    bus.ex_valid   = 1'b1;
    bus.alucontrol = op;
    bus.srca       = a;
    bus.srcb       = b;
    bus.hien       = 1'b0;
    bus.loen       = 1'b0;
    #1;
    r = ref_comb(op, a, b);
    check_output("comb_result", {32'd0, bus.aluresult}, {32'd0, r});
    check_output("comb_zero", {63'd0, bus.zero}, {63'd0, (r == 32'd0)});
    check_output("comb_stall", {63'd0, bus.stall}, 64'd0);
  endtask

  task automatic do_muldiv(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic he, input logic le);
    int     cycles, exp_len;
    longint sa, sb, p;
    logic [31:0] q, r;
    @(negedge clk);
    bus.ex_valid   = 1'b1;
    bus.alucontrol = op;
    bus.srca       = a;
    bus.srcb       = b;
    bus.hien       = he;
    bus.loen       = le;
    #1;
    check_output("muldiv_result0", {32'd0, bus.aluresult}, 64'd0);
    cycles = 0;
    while (bus.stall && cycles < 100) begin
      cycles++;
      @(negedge clk);
      bus.srca = $urandom;
      bus.srcb = $urandom;
      #1;
    end
    exp_len = 33;
`ifdef ALU_HILO_FAST_MUL_EN
    if (op == 4'b1000) exp_len = 1;
`endif
    check_output("stall_len", 64'(cycles), 64'(exp_len));
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op == 4'b1000) begin
      p = sa * sb;
      if (he) hi_exp = p[63:32];
      if (le) lo_exp = p[31:0];
    end else begin
      if (b == 32'd0) begin
        q = 32'hFFFF_FFFF;
        r = a;
      end else begin
        q = 32'(sa / sb);
        r = 32'(sa % sb);
      end
      if (he) hi_exp = r;
      if (le) lo_exp = q;
    end
    check_output("hi_done", {32'd0, bus.hi}, {32'd0, hi_exp});
    check_output("lo_done", {32'd0, bus.lo}, {32'd0, lo_exp});
    // Pipeline advances after DONE; MFLO and MFHI must see the freshly written pair exactly once.
    @(negedge clk);
    bus.alucontrol = 4'b1011;
    #1;
    check_output("mflo", {32'd0, bus.aluresult}, {32'd0, lo_exp});
    check_output("after_stall", {63'd0, bus.stall}, 64'd0);
    @(negedge clk);
    bus.alucontrol = 4'b1010;
    #1;
    check_output("mfhi", {32'd0, bus.aluresult}, {32'd0, hi_exp});
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    hi_exp   = 32'd0;
    lo_exp   = 32'd0;
    reset          = 1'b0;
    bus.ex_valid   = 1'b1;
    bus.alucontrol = 4'b1000;
    bus.srca       = 32'd3;
    bus.srcb       = 32'd4;
    bus.hien       = 1'b1;
    bus.loen       = 1'b1;
    #12;
    check_output("reset_stall", {63'd0, bus.stall}, 64'd0);
    check_output("reset_hi", {32'd0, bus.hi}, 64'd0);
    check_output("reset_lo", {32'd0, bus.lo}, 64'd0);
    @(negedge clk);
    bus.ex_valid = 1'b0;
    reset        = 1'b1;

    do_comb(4'b0010, 32'h7FFF_FFFF, 32'd1);
    do_comb(4'b0110, 32'd5, 32'd5);
    do_comb(4'b0111, 32'hFFFF_FFFF, 32'd1);
    do_comb(4'b0001, 32'h0000_00F0, 32'h0000_000F);
    do_comb(4'b0101, 32'h1234_5678, 32'h9ABC_DEF0);

    // Start requires ex_valid and at least one of hien/loen.
    @(negedge clk);
    bus.ex_valid   = 1'b0;
    bus.alucontrol = 4'b1000;
    bus.hien       = 1'b1;
    bus.loen       = 1'b1;
    #1;
    check_output("no_valid_stall", {63'd0, bus.stall}, 64'd0);
    bus.ex_valid = 1'b1;
    bus.hien     = 1'b0;
    bus.loen     = 1'b0;
    #1;
    check_output("no_en_stall", {63'd0, bus.stall}, 64'd0);

    do_muldiv(4'b1000, 32'hFFFF_FFFF, 32'd5, 1'b1, 1'b1);
    do_muldiv(4'b1001, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1);
    do_muldiv(4'b1001, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1);
    do_muldiv(4'b1001, 32'd9, 32'd0, 1'b1, 1'b1);

    // Abort a MULT mid-iteration with an asynchronous reset.
    @(negedge clk);
    bus.ex_valid   = 1'b1;
    bus.alucontrol = 4'b1000;
    bus.srca       = 32'h1234_5678;
    bus.srcb       = 32'h8765_4321;
    bus.hien       = 1'b1;
    bus.loen       = 1'b1;
    repeat (10) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    hi_exp = 32'd0;
    lo_exp = 32'd0;
    check_output("abort_stall", {63'd0, bus.stall}, 64'd0);
    check_output("abort_hi", {32'd0, bus.hi}, 64'd0);
    check_output("abort_lo", {32'd0, bus.lo}, 64'd0);
    @(negedge clk);
    bus.ex_valid = 1'b0;
    reset        = 1'b1;
    do_muldiv(4'b1000, 32'hFFFF_FFFE, 32'h7FFF_FFFF, 1'b1, 1'b1);

    for (int i = 0; i < 20; i++) begin
      logic [3:0] ops [8];
      ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1010, 4'b1011, 4'b1100};
      do_comb(ops[$urandom_range(7)], $urandom, $urandom);
    end

    for (int i = 0; i < 8; i++) begin
      logic he, le;
      logic [31:0] b;
      he = 1'($urandom_range(1));
      le = (he == 1'b0) ? 1'b1 : 1'($urandom_range(1));
      b  = ($urandom_range(3) == 0) ? 32'($urandom_range(7)) : $urandom;
      do_muldiv((i % 2 == 0) ? 4'b1000 : 4'b1001, $urandom, b, he, le);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
